// File: rtl/fpu_pkg.sv
// Shared FPU definitions: unit opcodes, collector state encoding and default word width.
package fpu_pkg;

  localparam int FPU_WIDTH = 32;

  localparam logic [2:0] OP_UNIT_A = 3'd0;
  localparam logic [2:0] OP_UNIT_B = 3'd1;
  localparam logic [2:0] OP_UNIT_C = 3'd2;
  localparam logic [2:0] OP_UNIT_D = 3'd3;
  localparam logic [2:0] OP_UNIT_E = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } col_state_t;

endpackage

// File: rtl/fpu_wdt_counter.sv
// Watchdog counter: counts enabled cycles, saturates at TIMEOUT-1 and flags expiry there.
module fpu_wdt_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Saturating rather than wrapping keeps the expiry flag asserted once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/fpu_result_collector.sv
// Waits for the issued unit's done strobe, captures its result and offers it on valid/ready;
// invalid opcodes and silent units come back as error results so the issuer never hangs.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int WIDTH     = FPU_WIDTH,
  parameter int NUM_UNITS = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [NUM_UNITS-1:0]       done_vec,
  input  logic [NUM_UNITS*WIDTH-1:0] res_bus,
  output logic [WIDTH-1:0]           result,
  output logic [2:0]                 op_out,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       busy,
  output logic                       err,
  output logic                       timeout
);

  col_state_t       r_state;
  col_state_t       w_next;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_op_out;
  logic             r_err;
  logic             r_timeout;

  logic             w_op_legal;
  logic             w_done;
  logic             w_expired;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic [WIDTH-1:0] w_sel_res;
  logic [WIDTH-1:0] w_res_arr [NUM_UNITS];

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_slice
    assign w_res_arr[g] = res_bus[g*WIDTH +: WIDTH];
  end

  assign w_op_legal = ({1'b0, op} < 4'(NUM_UNITS));
  // Only the issued unit's strobe matters; r_op_out is always legal while in WAIT.
  assign w_done     = done_vec[r_op_out];
  assign w_sel_res  = w_res_arr[r_op_out];
  assign w_cnt_clr  = (r_state == S_IDLE) && start && w_op_legal;
  assign w_cnt_en   = (r_state == S_WAIT);

  fpu_wdt_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_op_legal ? S_WAIT : S_HOLD;
      S_WAIT: if (w_done || w_expired) w_next = S_HOLD;
      S_HOLD: if (result_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != S_IDLE);
    result_valid = (r_state == S_HOLD);
  end

  // Result fields change only on capture, so they stay stable through HOLD and the following IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_op_out  <= OP_UNIT_A;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_out <= op;
            if (!w_op_legal) begin
              r_result  <= '0;
              r_err     <= 1'b1;
              r_timeout <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_result  <= w_sel_res;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
          end else if (w_expired) begin
            r_result  <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = r_result;
  assign op_out  = r_op_out;
  assign err     = r_err;
  assign timeout = r_timeout;

endmodule
